// File: rtl/cpu_pkg.sv
// Shared memory-stage types: unit state encoding, lane geometry and lane slicing.
// No logic of its own; imported by the memory unit and the writeback unpacker.
// No flow control here; purely declarative.
package cpu_pkg;

    localparam int VECTOR_DATA_WIDTH = 8;
    localparam int VECTOR_SIZE       = 6;
    localparam int SCALAR_DATA_WIDTH = VECTOR_SIZE * VECTOR_DATA_WIDTH;
    localparam int LANE_INDEX_WIDTH  = $clog2(VECTOR_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        DRAIN,
        DONE
    } memUnitState_t;

    function automatic logic [VECTOR_DATA_WIDTH-1:0] laneSlice(
        input logic [SCALAR_DATA_WIDTH-1:0] vector,
        input logic [LANE_INDEX_WIDTH-1:0]  lane
    );
        return vector[lane*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/lane_address_generator.sv
// Per-lane byte address accumulator: base on start, +stride (or +1) per step.
// Address and lane index are registered; a step is visible the cycle after.
// No backpressure; the caller simply withholds step.
module lane_address_generator
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 48,
    parameter int LANE_COUNT    = VECTOR_SIZE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        step,
    input  logic                        isVector,
    input  logic [ADDRESS_WIDTH-1:0]    base,
    input  logic [ADDRESS_WIDTH-1:0]    stride,
    output logic [ADDRESS_WIDTH-1:0]    laneAddress,
    output logic [LANE_INDEX_WIDTH-1:0] laneIndex,
    output logic                        laneLast
);

    logic [ADDRESS_WIDTH-1:0] increment;

    assign laneLast = (laneIndex == LANE_INDEX_WIDTH'(LANE_COUNT - 1));

    // Overflow past ADDRESS_WIDTH is dropped, giving the silent wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            laneAddress <= '0;
            laneIndex   <= '0;
            increment   <= '0;
        end else if (start) begin
            laneAddress <= base;
            laneIndex   <= '0;
            increment   <= isVector ? stride : ADDRESS_WIDTH'(1);
        end else if (step) begin
            laneAddress <= laneAddress + increment;
            laneIndex   <= laneIndex + LANE_INDEX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/vector_memory_unit.sv
// Memory-stage load/store sequencer: one byte lane per cycle to a byte-wide sync memory.
// Store responds 7 cycles after acceptance, load 8 (6 lanes + drain + done).
// Accepts only in IDLE; stall stays high until the response pulse has passed.
module vector_memory_unit
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 48,
    parameter int VECTOR_DATA_WIDTH = cpu_pkg::VECTOR_DATA_WIDTH,
    parameter int VECTOR_SIZE       = cpu_pkg::VECTOR_SIZE,
    parameter int SCALAR_DATA_WIDTH = cpu_pkg::SCALAR_DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         requestValid,
    output logic                         requestReady,
    input  logic                         isStore,
    input  logic                         isVector,
    input  logic [ADDRESS_WIDTH-1:0]     address,
    input  logic [ADDRESS_WIDTH-1:0]     stride,
    input  logic [SCALAR_DATA_WIDTH-1:0] storeData,
    output logic [ADDRESS_WIDTH-1:0]     memAddress,
    output logic                         memWriteEnable,
    output logic [VECTOR_DATA_WIDTH-1:0] memWriteData,
    input  logic [VECTOR_DATA_WIDTH-1:0] memReadData,
    output logic                         responseValid,
    output logic [SCALAR_DATA_WIDTH-1:0] loadData,
    output logic                         stall
);

    memUnitState_t                state;
    logic [SCALAR_DATA_WIDTH-1:0] dataReg;
    logic [LANE_INDEX_WIDTH-1:0]  laneIndex;
    logic                         laneLast;
    logic                         genStart;
    logic                         genStep;

    assign requestReady = (state == IDLE);
    assign stall        = (state != IDLE);
    assign genStart     = (state == IDLE) && requestValid;
    assign genStep      = ((state == STORE) || (state == LOAD)) && !laneLast;

    lane_address_generator #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LANE_COUNT    (VECTOR_SIZE)
    ) u_laneAddressGenerator (
        .clock       (clock),
        .reset       (reset),
        .start       (genStart),
        .step        (genStep),
        .isVector    (isVector),
        .base        (address),
        .stride      (stride),
        .laneAddress (memAddress),
        .laneIndex   (laneIndex),
        .laneLast    (laneLast)
    );

    // dataReg holds store lanes, or collects load lanes so loadData only moves on completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            dataReg        <= '0;
            memWriteEnable <= 1'b0;
            memWriteData   <= '0;
            responseValid  <= 1'b0;
            loadData       <= '0;
        end else begin
            responseValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (requestValid) begin
                        dataReg <= storeData;
                        if (isStore) begin
                            state          <= STORE;
                            memWriteEnable <= 1'b1;
                            memWriteData   <= storeData[VECTOR_DATA_WIDTH-1:0];
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                STORE: begin
                    if (laneLast) begin
                        state          <= DONE;
                        memWriteEnable <= 1'b0;
                        responseValid  <= 1'b1;
                    end else begin
                        memWriteData <= laneSlice(dataReg, laneIndex + LANE_INDEX_WIDTH'(1));
                    end
                end
                LOAD: begin
                    // Read data lags the presented address by one cycle.
                    if (laneIndex != '0) begin
                        dataReg[(int'(laneIndex) - 1)*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH] <= memReadData;
                    end
                    if (laneLast) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    loadData      <= {memReadData, dataReg[SCALAR_DATA_WIDTH-VECTOR_DATA_WIDTH-1:0]};
                    state         <= DONE;
                    responseValid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_memory_unit.sv
// Directed bench for vector_memory_unit with a byte-wide synchronous memory model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_vector_memory_unit;

    logic        clock;
    logic        reset;
    logic        requestValid;
    logic        requestReady;
    logic        isStore;
    logic        isVector;
    logic [47:0] address;
    logic [47:0] stride;
    logic [47:0] storeData;
    logic [47:0] memAddress;
    logic        memWriteEnable;
    logic [7:0]  memWriteData;
    logic [7:0]  memReadData;
    logic        responseValid;
    logic [47:0] loadData;
    logic        stall;

    logic [7:0]  mem [logic [47:0]];
    int          writeCount = 0;
    int          respCount  = 0;
    int          passCount  = 0;
    int          checkCount = 0;

    vector_memory_unit dut (
        .clock          (clock),
        .reset          (reset),
        .requestValid   (requestValid),
        .requestReady   (requestReady),
        .isStore        (isStore),
        .isVector       (isVector),
        .address        (address),
        .stride         (stride),
        .storeData      (storeData),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData),
        .responseValid  (responseValid),
        .loadData       (loadData),
        .stall          (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first synchronous memory; unwritten bytes read as zero.
    always @(posedge clock) begin
        memReadData <= mem.exists(memAddress) ? mem[memAddress] : 8'h00;
        if (memWriteEnable) begin
            mem[memAddress] = memWriteData;
            writeCount++;
        end
        if (responseValid) respCount++;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] memByte(input logic [47:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic runStore(input logic [47:0] addr, input logic [47:0] strd,
                            input logic vec, input logic [47:0] data);
        logic [47:0] expA;
        address = addr; stride = strd; isVector = vec; isStore = 1'b1;
        storeData = data; requestValid = 1'b1;
        tick;
        requestValid = 1'b0;
        storeData = ~data;
        address = ~addr;
        stride = ~strd;
        for (int i = 0; i < 6; i++) begin
            expA = addr + 48'(i) * (vec ? strd : 48'd1);
            check("store_addr", memAddress, expA);
            check("store_data", memWriteData, (data >> (8*i)) & 48'hFF);
            check("store_we", memWriteEnable, 1'b1);
            check("store_stall", stall, 1'b1);
            tick;
        end
        check("store_resp", responseValid, 1'b1);
        check("store_we_done", memWriteEnable, 1'b0);
        tick;
        check("store_resp_pulse", responseValid, 1'b0);
        check("store_ready", requestReady, 1'b1);
    endtask

    task automatic runLoad(input logic [47:0] addr, input logic [47:0] strd,
                           input logic vec, input logic [47:0] expData);
        logic [47:0] expA;
        int w0;
        w0 = writeCount;
        address = addr; stride = strd; isVector = vec; isStore = 1'b0;
        storeData = 48'h0; requestValid = 1'b1;
        tick;
        requestValid = 1'b0;
        address = ~addr;
        stride = ~strd;
        expA = addr;
        for (int i = 0; i < 6; i++) begin
            expA = addr + 48'(i) * (vec ? strd : 48'd1);
            check("load_addr", memAddress, expA);
            check("load_we", memWriteEnable, 1'b0);
            check("load_resp_early", responseValid, 1'b0);
            tick;
        end
        check("drain_addr", memAddress, expA);
        check("drain_resp", responseValid, 1'b0);
        tick;
        check("load_resp", responseValid, 1'b1);
        check("load_data", loadData, expData);
        tick;
        check("load_resp_pulse", responseValid, 1'b0);
        check("load_data_hold", loadData, expData);
        check("load_idle", stall, 1'b0);
        check("load_no_writes", writeCount, w0);
    endtask

    initial begin
        int w0;
        int r0;
        int n;
        reset = 1'b0;
        requestValid = 1'b0; isStore = 1'b0; isVector = 1'b0;
        address = '0; stride = '0; storeData = '0;
        #12;
        check("rst_ready", requestReady, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_we", memWriteEnable, 1'b0);
        check("rst_addr", memAddress, 48'h0);
        check("rst_wdata", memWriteData, 8'h0);
        check("rst_resp", responseValid, 1'b0);
        check("rst_load", loadData, 48'h0);
        tick;
        reset = 1'b1;
        tick;

        // Scalar store.
        runStore(48'h100, 48'h0, 1'b0, 48'h0605_0403_0201);
        for (int i = 0; i < 6; i++)
            check("store_mem", memByte(48'h100 + 48'(i)), 8'(i + 1));
        check("store_write_count", writeCount, 6);
        check("store_keeps_load", loadData, 48'h0);

        // Scalar load of a freshly stored pattern.
        runStore(48'h200, 48'h0, 1'b0, 48'hFFEE_DDCC_BBAA);
        runLoad(48'h200, 48'h0, 1'b0, 48'hFFEE_DDCC_BBAA);

        // Strided vector store then load.
        runStore(48'h10, 48'h4, 1'b1, 48'h6050_4030_2010);
        check("vstore_mem_1c", memByte(48'h1C), 8'h40);
        check("vstore_gap", memByte(48'h11), 8'h00);
        runLoad(48'h10, 48'h4, 1'b1, 48'h6050_4030_2010);

        // Wrap past the top of the address space.
        runStore(48'hFFFF_FFFF_FFFE, 48'h0, 1'b0, 48'h6655_4433_2211);
        check("wrap_keeps_load", loadData, 48'h6050_4030_2010);
        check("wrap_top", memByte(48'hFFFF_FFFF_FFFF), 8'h22);
        check("wrap_0", memByte(48'h0), 8'h33);
        check("wrap_3", memByte(48'h3), 8'h66);

        // Broadcast load: stride 0 repeats mem[2].
        runLoad(48'h2, 48'h0, 1'b1, 48'h5555_5555_5555);

        // Reset in the middle of a store.
        w0 = writeCount;
        r0 = respCount;
        address = 48'h300; stride = 48'h0; isVector = 1'b0; isStore = 1'b1;
        storeData = 48'hA6A5_A4A3_A2A1; requestValid = 1'b1;
        tick;
        requestValid = 1'b0;
        tick; tick; tick;
        check("mid_we_before", memWriteEnable, 1'b1);
        check("mid_writes_before", writeCount - w0, 3);
        reset = 1'b0;
        #1;
        check("mid_we_async", memWriteEnable, 1'b0);
        check("mid_addr", memAddress, 48'h0);
        check("mid_wdata", memWriteData, 8'h0);
        check("mid_stall", stall, 1'b0);
        check("mid_ready", requestReady, 1'b1);
        check("mid_load", loadData, 48'h0);
        tick; tick;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        check("mid_write_count", writeCount - w0, 3);
        check("mid_no_resp", respCount - r0, 0);
        check("mid_lane2", memByte(48'h302), 8'hA3);
        check("mid_lane3_absent", mem.exists(48'h303), 1'b0);

        // Back-to-back stores with requestValid held.
        address = 48'h400; isVector = 1'b0; isStore = 1'b1;
        storeData = 48'h0B0A_0908_0706; requestValid = 1'b1;
        tick;
        address = 48'h500;
        storeData = 48'h1B1A_1918_1716;
        for (int i = 0; i < 6; i++) begin
            check("b2b_addr", memAddress, 48'h400 + 48'(i));
            check("b2b_data", memWriteData, 8'(6 + i));
            check("b2b_not_ready", requestReady, 1'b0);
            tick;
        end
        check("b2b_done_not_ready", requestReady, 1'b0);
        check("b2b_resp", responseValid, 1'b1);
        tick;
        check("b2b_idle_ready", requestReady, 1'b1);
        check("b2b_idle_we", memWriteEnable, 1'b0);
        tick;
        requestValid = 1'b0;
        check("b2b_second_addr", memAddress, 48'h500);
        check("b2b_second_we", memWriteEnable, 1'b1);
        check("b2b_second_data", memWriteData, 8'h16);
        n = 0;
        while (responseValid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("b2b_second_resp", responseValid, 1'b1);
        tick;
        check("b2b_first_last", memByte(48'h405), 8'h0B);
        check("b2b_second_last", memByte(48'h505), 8'h1B);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
